// File: rtl/apb2ahb_bridge.sv
// APB slave to AHB-Lite bridge issuing one single NONSEQ transfer per APB access.
// Define APB2AHB_APB4_EN to add PPROT/PSTRB with narrow-write lane mapping.
module apb2ahb_bridge #(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [31:0]          PWDATA,
`ifdef APB2AHB_APB4_EN
  input  logic [2:0]           PPROT,
  input  logic [3:0]           PSTRB,
`endif
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [3:0]           HPROT,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  localparam logic [ADDRWIDTH-1:0] LANE_MASK = ADDRWIDTH'(3);

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [2:0]             size_q, size_d;
  logic [3:0]             prot_q, prot_d;
  logic [31:0]            prdata_q, prdata_d;
  logic                   err_q, err_d;

  logic [2:0]             size_s;
  logic [1:0]             lane_s;
  logic [3:0]             prot_s;
  logic                   bad_s;

  // Transfer attributes derived from the APB setup phase
  always_comb begin
    size_s = 3'b010;
    lane_s = 2'b00;
    prot_s = 4'b0011;
    bad_s  = 1'b0;
`ifdef APB2AHB_APB4_EN
    prot_s = {1'b0, 1'b0 & PPROT[1], PPROT[0], ~PPROT[2]};
    if (PWRITE) begin
      case (PSTRB)
        4'b1111: size_s = 3'b010;
        4'b0011: size_s = 3'b001;
        4'b1100: begin
          size_s = 3'b001;
          lane_s = 2'b10;
        end
        4'b0001: size_s = 3'b000;
        4'b0010: begin
          size_s = 3'b000;
          lane_s = 2'b01;
        end
        4'b0100: begin
          size_s = 3'b000;
          lane_s = 2'b10;
        end
        4'b1000: begin
          size_s = 3'b000;
          lane_s = 2'b11;
        end
        default: bad_s = 1'b1;
      endcase
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    prot_d   = prot_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (PCLKEN && PSEL && !PENABLE) begin
          addr_d  = (PADDR & ~LANE_MASK) | ADDRWIDTH'(lane_s);
          write_d = PWRITE;
          wdata_d = PWDATA;
          size_d  = size_s;
          prot_d  = prot_s;
          // Unsupported strobe patterns answer with an error, no AHB traffic
          if (bad_s) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          if (!write_q) prdata_d = HRDATA;
          err_d   = HRESP;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (PCLKEN && (!PSEL || PENABLE)) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      size_q   <= 3'b010;
      prot_q   <= 4'b0011;
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      prot_q   <= prot_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

  assign HTRANS  = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR   = addr_q;
  assign HWRITE  = write_q;
  assign HSIZE   = size_q;
  assign HPROT   = prot_q;
  assign HWDATA  = wdata_q;
  assign PRDATA  = prdata_q;
  assign PREADY  = (state_q == S_RESP);
  assign PSLVERR = PREADY & err_q;

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Randomized bench for apb2ahb_bridge against a schedule-level transaction model.
module tb_apb2ahb_bridge;
  localparam int AW = 16;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic PCLKEN = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [2:0] PPROT = '0;
  logic [3:0] PSTRB = 4'hF;
  logic [31:0] PRDATA;
  logic PREADY, PSLVERR;
  logic [AW-1:0] HADDR;
  logic [1:0] HTRANS;
  logic HWRITE;
  logic [2:0] HSIZE;
  logic [3:0] HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic HREADY = 1'b1, HRESP = 1'b0;

  apb2ahb_bridge #(.ADDRWIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB2AHB_APB4_EN
    .PPROT(PPROT), .PSTRB(PSTRB),
`endif
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Expected phase: 0 idle, 1 address, 2 data, 3 response
  int ph = 0;
  bit chk_on = 1'b0;
  bit t_w = 1'b0, t_err = 1'b0;
  logic [31:0] t_wdata = '0, m_prdata = '0;
  logic [AW-1:0] t_haddr = '0;
  logic [2:0] t_size = 3'b010;
  logic [3:0] t_prot = 4'b0011;

  int t0 = 0, obs_ns = -1, obs_rdy = -1, obs_rdy_n = 0;
  logic [AW-1:0] obs_haddr = '0;
  logic [2:0] obs_size = '0;
  logic [31:0] obs_hwdata = '0;
  bit obs_err = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_on) begin
      check("HTRANS", 32'(HTRANS), (ph == 1) ? 32'd2 : 32'd0);
      check("PREADY", 32'(PREADY), 32'(ph == 3));
      check("PSLVERR", 32'(PSLVERR), 32'(ph == 3 && t_err));
      check("PRDATA", PRDATA, m_prdata);
      if (ph == 1) begin
        check("HADDR", 32'(HADDR), 32'(t_haddr));
        check("HWRITE", 32'(HWRITE), 32'(t_w));
        check("HSIZE", 32'(HSIZE), 32'(t_size));
        check("HPROT", 32'(HPROT), 32'(t_prot));
      end
      if (ph == 2 && t_w) check("HWDATA", HWDATA, t_wdata);
      if (HTRANS == 2'b10 && obs_ns < 0) begin
        obs_ns = cyc;
        obs_haddr = HADDR;
        obs_size = HSIZE;
      end
      if (HTRANS == 2'b00 && obs_ns >= 0 && obs_rdy < 0 && !PREADY)
        obs_hwdata = HWDATA;
      if (PREADY) begin
        if (obs_rdy < 0) begin
          obs_rdy = cyc;
          obs_err = PSLVERR;
        end
        obs_rdy_n++;
      end
    end
  end

  function automatic void model(input bit w, input logic [AW-1:0] a,
      input logic [3:0] st, input logic [2:0] pp,
      output logic [AW-1:0] ha, output logic [2:0] sz,
      output logic [3:0] pr, output bit bad);
    ha = {a[AW-1:2], 2'b00};
    sz = 3'b010;
    pr = 4'b0011;
    bad = 1'b0;
`ifdef APB2AHB_APB4_EN
    pr = {2'b00, pp[0], ~pp[2]};
    if (w) begin
      if (st == 4'hF) sz = 3'b010;
      else if (st == 4'h3 || st == 4'hC) begin
        sz = 3'b001;
        ha[1] = st[2];
      end else if ($countones(st) == 1) begin
        sz = 3'b000;
        for (int i = 0; i < 4; i++) if (st[i]) ha[1:0] = 2'(i);
      end else bad = 1'b1;
    end
`endif
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ph = 0;
      PSEL = 1'($urandom);
      PENABLE = 1'b1;
      PCLKEN = 1'($urandom);
      PADDR = AW'($urandom);
      HREADY = 1'($urandom);
      HRESP = 1'($urandom);
      @(posedge HCLK); #1;
    end
    PSEL = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic run_txn(input bit w, input logic [AW-1:0] a,
      input logic [31:0] d, input int aw, input int dw, input bit e,
      input logic [31:0] rd, input int pg, input int sg,
      input logic [3:0] st, input logic [2:0] pp, input bit ab);
    bit bad;
    model(w, a, st, pp, t_haddr, t_size, t_prot, bad);
    t_w = w;
    t_wdata = d;
    PADDR = a; PWRITE = w; PWDATA = d; PSTRB = st; PPROT = pp;
    for (int i = 0; i < sg; i++) begin
      ph = 0; PSEL = 1'b1; PENABLE = 1'b0; PCLKEN = 1'b0;
      @(posedge HCLK); #1;
    end
    ph = 0; PSEL = 1'b1; PENABLE = 1'b0; PCLKEN = 1'b1;
    t0 = cyc; obs_ns = -1; obs_rdy = -1; obs_rdy_n = 0;
    @(posedge HCLK); #1;
    if (!bad) begin
      for (int i = 0; i <= aw; i++) begin
        ph = 1;
        HREADY = (i == aw); HRESP = 1'b0;
        PCLKEN = 1'($urandom); PENABLE = 1'($urandom);
        @(posedge HCLK); #1;
      end
      for (int i = 0; i <= dw; i++) begin
        ph = 2;
        HREADY = (i == dw);
        HRESP = e && (i + 1 >= dw);
        HRDATA = (i == dw) ? rd : $urandom;
        PCLKEN = 1'($urandom); PENABLE = 1'($urandom);
        @(posedge HCLK); #1;
      end
    end
    ph = 3;
    t_err = bad ? 1'b1 : e;
    if (!w && !bad) m_prdata = rd;
    HREADY = 1'($urandom); HRESP = 1'($urandom); HRDATA = $urandom;
    for (int i = 0; i < pg; i++) begin
      PCLKEN = 1'b0; PSEL = 1'($urandom); PENABLE = 1'($urandom);
      @(posedge HCLK); #1;
    end
    PCLKEN = 1'b1;
    if (ab) PSEL = 1'b0;
    else begin
      PSEL = 1'b1; PENABLE = 1'b1;
    end
    @(posedge HCLK); #1;
    ph = 0; t_err = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PCLKEN = 1'($urandom);
  endtask

  task automatic reset_mid();
    PSEL = 1'b1; PENABLE = 1'b0; PCLKEN = 1'b1;
    PADDR = 16'h0040; PWRITE = 1'b0; PSTRB = 4'hF;
    t0 = cyc; obs_ns = -1; obs_rdy = -1; obs_rdy_n = 0;
    model(1'b0, 16'h0040, 4'hF, 3'b000, t_haddr, t_size, t_prot, t_err);
    t_w = 1'b0; t_err = 1'b0; ph = 0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1; HREADY = 1'b1; HRESP = 1'b0; ph = 1;
    @(posedge HCLK); #1;
    HREADY = 1'b0; ph = 2;
    #1;
    HRESETn = 1'b0; ph = 0; m_prdata = '0; t_err = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    check("rst_mid_HTRANS", 32'(HTRANS), 32'd0);
    check("rst_mid_PREADY", 32'(PREADY), 32'd0);
    check("rst_mid_PRDATA", PRDATA, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1; HREADY = 1'b1;
  endtask

  initial begin
    bit w;
    logic [3:0] st;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_HTRANS", 32'(HTRANS), 32'd0);
    check("rst_HADDR", 32'(HADDR), 32'd0);
    check("rst_HWRITE", 32'(HWRITE), 32'd0);
    check("rst_HSIZE", 32'(HSIZE), 32'd2);
    check("rst_HPROT", 32'(HPROT), 32'd3);
    check("rst_HWDATA", HWDATA, 32'd0);
    check("rst_PRDATA", PRDATA, 32'd0);
    check("rst_PREADY", 32'(PREADY), 32'd0);
    check("rst_PSLVERR", 32'(PSLVERR), 32'd0);
    HRESETn = 1'b1;
    chk_on = 1'b1;
    idle(2);

    run_txn(1, 16'h0010, 32'hA5A5_1234, 0, 0, 0, 32'h0, 0, 0,
            4'hF, 3'b000, 0);
    check("wr_ns_cycle", 32'(obs_ns - t0), 32'd1);
    check("wr_haddr", 32'(obs_haddr), 32'h0010);
    check("wr_hwdata", obs_hwdata, 32'hA5A5_1234);
    check("wr_ready_cycle", 32'(obs_rdy - t0), 32'd3);
    check("wr_slverr", 32'(obs_err), 32'd0);
    idle(1);

    run_txn(0, 16'h0024, $urandom, 0, 2, 0, 32'hCAFE_F00D, 0, 0,
            4'hF, 3'b000, 0);
    check("rd_ready_cycle", 32'(obs_rdy - t0), 32'd5);
    check("rd_prdata", PRDATA, 32'hCAFE_F00D);
    idle(1);

    run_txn(0, 16'h0100, $urandom, 0, 1, 1, 32'h1111_2222, 0, 0,
            4'hF, 3'b000, 0);
    check("err_slverr", 32'(obs_err), 32'd1);
    run_txn(0, 16'h0104, $urandom, 0, 0, 0, 32'h3333_4444, 0, 0,
            4'hF, 3'b000, 0);
    check("after_err_slverr", 32'(obs_err), 32'd0);

    run_txn(1, 16'h0200, 32'h0BAD_0BAD, 1, 0, 0, 32'h5555_6666, 3, 2,
            4'hF, 3'b000, 0);
    check("pclken_ready_len", 32'(obs_rdy_n), 32'd4);

    run_txn(1, 16'h0300, 32'h1234_5678, 0, 0, 0, $urandom, 0, 0,
            4'hF, 3'b000, 1);
    run_txn(0, 16'h0304, $urandom, 0, 0, 0, 32'h7777_8888, 0, 0,
            4'hF, 3'b000, 0);
    check("after_abort_ready_cycle", 32'(obs_rdy - t0), 32'd3);

`ifdef APB2AHB_APB4_EN
    run_txn(1, 16'h0030, 32'hDEAD_BEEF, 0, 0, 0, $urandom, 0, 0,
            4'b0100, 3'b001, 0);
    check("apb4_hsize", 32'(obs_size), 32'd0);
    check("apb4_haddr", 32'(obs_haddr), 32'h0032);
    run_txn(1, 16'h0030, 32'hDEAD_BEEF, 0, 0, 0, $urandom, 0, 0,
            4'b0101, 3'b000, 0);
    check("apb4_bad_no_ns", 32'(obs_ns), 32'hFFFF_FFFF);
    check("apb4_bad_slverr", 32'(obs_err), 32'd1);
`endif

    reset_mid();
    run_txn(0, 16'h0044, $urandom, 0, 0, 0, 32'h9999_AAAA, 0, 0,
            4'hF, 3'b000, 0);
    check("post_rst_ready_cycle", 32'(obs_rdy - t0), 32'd3);
    check("post_rst_prdata", PRDATA, 32'h9999_AAAA);

    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom);
      st = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      run_txn(w, AW'($urandom), $urandom, $urandom_range(0, 2),
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
              $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
              st, 3'($urandom), ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 2));
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb2ahb_bridge.md
APB2AHB_BRIDGE -- requirements
Module: apb2ahb_bridge

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 16, width of PADDR/HADDR; data width fixed at 32.
REQ-002 SHALL have port HCLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port PCLKEN  input  1  APB clock enable; APB inputs sampled and APB access completes only on HCLK edges with PCLKEN=1.
REQ-005 SHALL have port PSEL  input  1  APB select.
REQ-006 SHALL have port PENABLE  input  1  APB access phase.
REQ-007 SHALL have port PADDR  input  ADDRWIDTH  APB address.
REQ-008 SHALL have port PWRITE  input  1  APB direction, 1=write.
REQ-009 SHALL have port PWDATA  input  32  APB write data.
REQ-010 SHALL have port PRDATA  output  32  APB read data, registered.
REQ-011 SHALL have port PREADY  output  1  APB ready.
REQ-012 SHALL have port PSLVERR  output  1  APB error, valid only with PREADY=1.
REQ-013 SHALL have port HADDR  output  ADDRWIDTH  AHB address.
REQ-014 SHALL have port HTRANS  output  2  AHB transfer type; only IDLE(00) and NONSEQ(10) issued.
REQ-015 SHALL have port HWRITE  output  1  AHB direction.
REQ-016 SHALL have port HSIZE  output  3  AHB size.
REQ-017 SHALL have port HPROT  output  4  AHB protection.
REQ-018 SHALL have port HWDATA  output  32  AHB write data.
REQ-019 SHALL have port HRDATA  input  32  AHB read data.
REQ-020 SHALL have port HREADY  input  1  AHB bus ready.
REQ-021 SHALL have port HRESP  input  1  AHB response, 1=ERROR.

Function
REQ-022 SHALL implement FSM states IDLE, ADDR, DATA, RESP; only single (non-burst) AHB transfers.
REQ-023 IDLE: on PCLKEN & PSEL & !PENABLE SHALL capture PADDR, PWRITE, PWDATA and go to ADDR; else stay.
REQ-024 ADDR: SHALL drive HTRANS=NONSEQ, HADDR/HWRITE/HSIZE/HPROT from captured values; go to DATA when HREADY=1, else hold all address-phase outputs.
REQ-025 DATA: SHALL drive HTRANS=IDLE and HWDATA=captured write data; when HREADY=1 capture HRDATA into PRDATA (reads only; writes leave PRDATA unchanged), capture HRESP into error flag, go to RESP.
REQ-026 DATA with HRESP=1, HREADY=0 (first error cycle) SHALL keep waiting; error taken on the HREADY=1 cycle.
REQ-027 RESP: PREADY=1, PSLVERR=error flag; on PCLKEN & PSEL & PENABLE go to IDLE and clear error flag; on PCLKEN & !PSEL (protocol violation) go to IDLE, result discarded.
REQ-028 PREADY SHALL be 0 in IDLE, ADDR, DATA; PSLVERR SHALL be 0 whenever PREADY=0.
REQ-029 Latency with PCLKEN=1, zero-wait AHB: setup cycle T0, NONSEQ in T1, data phase T2, PREADY=1 in T3; each AHB wait state adds one cycle.
REQ-030 HTRANS SHALL never be NONSEQ outside ADDR; new APB setup phases during ADDR/DATA/RESP SHALL be ignored.

Reset
REQ-031 On HRESETn=0 SHALL go to IDLE asynchronously: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HPROT=0011, HWDATA=0, PRDATA=0, PREADY=0, PSLVERR=0, error flag=0.
REQ-032 Reset mid-transfer SHALL abandon the transfer; first setup after release starts a fresh access.

Configuration
REQ-033 Macro APB2AHB_APB4_EN defined: SHALL add inputs PPROT[2:0] and PSTRB[3:0], captured at setup; HPROT={2'b00, PPROT[0], ~PPROT[2]}; write PSTRB 1111->HSIZE=010, HADDR[1:0]=00; 0011/1100->HSIZE=001, HADDR[1:0]=00/10; one-hot->HSIZE=000, HADDR[1:0]=lane index; any other pattern (incl. 0000)->no AHB transfer, IDLE->RESP directly with PSLVERR=1.
REQ-034 Macro APB2AHB_APB4_EN undefined: no PPROT/PSTRB ports; HSIZE=010, HPROT=0011, HADDR[1:0]=00 for all transfers.
REQ-035 Reads SHALL always use HSIZE=010, HADDR[1:0]=00 in both configurations.

Verification
REQ-036 Write PADDR=0x0010, PWDATA=0xA5A5_1234, HREADY=1 -> NONSEQ HADDR=0x0010 at T1, HWDATA=0xA5A5_1234 at T2, PREADY=1 at T3, PSLVERR=0.
REQ-037 Read PADDR=0x0024, HRDATA=0xCAFE_F00D, HREADY low 2 data cycles -> PREADY=1 at T5, PRDATA=0xCAFE_F00D.
REQ-038 Read with HRESP=1 two-cycle error -> PREADY=1, PSLVERR=1; following access has PSLVERR=0.
REQ-039 PCLKEN toggling 1/0 during RESP -> PREADY held until PCLKEN=1 edge with PENABLE=1, then IDLE.
REQ-040 APB2AHB_APB4_EN: PSTRB=0100, PADDR=0x0030 -> HSIZE=000, HADDR=0x0032; PSTRB=0101 -> no NONSEQ, PSLVERR=1.
REQ-041 HRESETn asserted in DATA -> HTRANS=00, PREADY=0 immediately; next access after release completes normally.
